// File: rtl/mod_ctrl.sv
// mod_ctrl: control unit for a repeated-subtraction modulo datapath (A mod B).
//
// Accepts an operand pair on a valid/ready handshake, registers it onto op_a/op_b,
// loads the datapath (save_A), then issues one subtract per cycle until the
// datapath reports TEMP < B. The subtraction count is the quotient. Divide-by-zero
// and an iteration-limit timeout are reported via err_code. The result is held
// on a valid/ready output handshake until the consumer takes it.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready only in IDLE, low in reset)
//   in_a, in_b          dividend / divisor
//   op_a, op_b          registered operands to datapath
//   save_A, subtract    datapath strobes, decoded from state
//   less_than_B         datapath flag TEMP < B
//   out_valid/out_ready result handshake
//   quotient, err_code  subtraction count; 00 ok, 01 div-by-zero, 10 timeout
//   busy                high outside IDLE
module mod_ctrl #(
    parameter int WIDTH    = 32,
    parameter int MAX_ITER = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             save_A,
    output logic             subtract,
    input  logic             less_than_B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [1:0]       err_code,
    output logic             busy
);

    localparam int IW = $clog2(MAX_ITER + 1);

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_TOUT = 2'b10;

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] iter_cnt;
    logic          accept;
    logic          at_limit;

    assign accept   = in_valid && in_ready;
    assign at_limit = (iter_cnt == IW'(MAX_ITER));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and strobes, all decoded from the state register.
    // in_ready also qualifies on rst_n so nothing is accepted while reset is held.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        save_A    = 1'b0;
        subtract  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = rst_n;
                if (in_valid && rst_n)
                    state_nxt = (in_b == '0) ? DONE : LOAD;
            end
            LOAD: begin
                save_A    = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                // Remainder reached, or the iteration limit hit: no subtract on exit.
                if (less_than_B || at_limit) state_nxt = DONE;
                else                         subtract  = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            quotient <= '0;
            err_code <= ERR_OK;
            iter_cnt <= '0;
        end else begin
            if (accept) begin
                op_a     <= in_a;
                op_b     <= in_b;
                quotient <= '0;
                iter_cnt <= '0;
                err_code <= (in_b == '0) ? ERR_DIV0 : ERR_OK;
            end else if (state == CHECK && !less_than_B) begin
                if (at_limit) begin
                    err_code <= ERR_TOUT;
                end else begin
                    // MAX_ITER <= 2^WIDTH-1, so the quotient cannot wrap here.
                    quotient <= quotient + WIDTH'(1);
                    iter_cnt <= iter_cnt + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_ctrl.sv
// Self-checking bench for mod_ctrl with a behavioural modulo datapath model.
module tb_mod_ctrl;

    localparam int W    = 16;
    localparam int MAXI = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [W-1:0] op_a, op_b;
    logic         save_A, subtract;
    logic         less_than_B;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] quotient;
    logic [1:0]   err_code;
    logic         busy;

    mod_ctrl #(.WIDTH(W), .MAX_ITER(MAXI)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .op_a(op_a), .op_b(op_b),
        .save_A(save_A), .subtract(subtract),
        .less_than_B(less_than_B),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .err_code(err_code),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Datapath model: TEMP register, load on save_A, subtract B on subtract.
    logic [W-1:0] temp = '0;
    always @(posedge clk) begin
        if (save_A)        temp <= op_a;
        else if (subtract) temp <= temp - op_b;
    end
    assign less_than_B = (temp < op_b);

    // Free-running strobe counters; transactions take differences.
    int n_save = 0, n_sub = 0;
    always @(posedge clk) begin
        if (save_A)   n_save <= n_save + 1;
        if (subtract) n_sub  <= n_sub + 1;
    end

    typedef struct {
        logic [W-1:0] q;
        logic [1:0]   err;
        logic [W-1:0] rem;
        int           lat;
        int           saves;
    } exp_t;

    exp_t sb[$];

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W-1:0] t;
        e.q = '0; e.err = 2'b00; t = a; e.saves = 1;
        if (b == '0) begin
            e.err = 2'b01; e.lat = 1; e.saves = 0;
        end else begin
            while (t >= b) begin
                if (e.q == W'(MAXI)) begin e.err = 2'b10; break; end
                t = t - b;
                e.q = e.q + 1'b1;
            end
            e.lat = int'(e.q) + 3;
        end
        e.rem = t;
        return e;
    endfunction

    // Drive one operand pair, then wait for the result and score it.
    // hold > 0: keep out_ready low for that many cycles in DONE while poking in_valid.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        exp_t e;
        int   edges, s0, u0;
        @(negedge clk);
        out_ready = (hold == 0);
        in_valid = 1'b1; in_a = a; in_b = b;
        sb.push_back(model(a, b));
        chk("in_ready_idle", in_ready, 1);
        s0 = n_save; u0 = n_sub;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0; in_a = ~a; in_b = ~b;
        while (!out_valid && edges < 100) begin
            @(posedge clk); edges++; @(negedge clk);
        end
        e = sb.pop_front();
        chk("latency", edges, e.lat);
        chk("quotient", quotient, e.q);
        chk("err_code", err_code, e.err);
        chk("save_pulses", n_save - s0, e.saves);
        chk("sub_pulses", n_sub - u0, int'(e.q));
        if (e.err == 2'b00) chk("remainder", temp, e.rem);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_a = 16'd3; in_b = 16'd1;
            @(posedge clk); @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_quot", quotient, e.q);
            chk("hold_err", err_code, e.err);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        if (hold > 0) begin
            out_ready = 1'b1;
            @(posedge clk); @(negedge clk);
            chk("hold_release_busy", busy, 0);
            chk("hold_release_valid", out_valid, 0);
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quot", quotient, 0);
        chk("rst_err", err_code, 0);
        chk("rst_op_a", op_a, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        run_txn(16'd7,   16'd3, 0);   // Q=2 rem 1
        run_txn(16'd2,   16'd5, 0);   // A<B
        run_txn(16'd9,   16'd0, 0);   // divide by zero
        run_txn(16'd100, 16'd1, 0);   // timeout at MAX_ITER
        run_txn(16'd9,   16'd2, 0);   // exactly MAX_ITER subtractions, no timeout
        run_txn(16'd11,  16'd4, 5);   // held result, in_valid ignored
        run_txn(16'd3,   16'd3, 0);   // A==B

        // Reset mid-CHECK aborts silently
        @(negedge clk);
        in_valid = 1'b1; in_a = 16'd50; in_b = 16'd3;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_subtract", subtract, 0);
        chk("abort_save", save_A, 0);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_quot", quotient, 0);
        @(negedge clk); rst_n = 1'b1;
        run_txn(16'd10, 16'd4, 0);    // Q=2 rem 2

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
